// File: rtl/credit_rx_buffer.sv
// rtl/credit_rx_buffer.sv - receive buffer for a credit-based link, one credit returned per consumed word
// Optional sticky overflow detection and port o_overflow under `ifdef CREDIT_RX_OVF_DET_EN.
module credit_rx_buffer #(
  parameter int N_CREDITS  = 10,
  parameter int DATA_WIDTH = 32,
  localparam int CW = $clog2(N_CREDITS + 1),
  localparam int PW = (N_CREDITS > 1) ? $clog2(N_CREDITS) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic                  o_credit,
`ifdef CREDIT_RX_OVF_DET_EN
  output logic                  o_overflow,
`endif
  output logic [CW-1:0]         o_count
);

  logic [DATA_WIDTH-1:0] mem_q [N_CREDITS];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  credit_q, credit_d;
  logic                  full, push, pop;

  // Depth need not be a power of two, so wrap on the last index instead of masking.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N_CREDITS - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full     = (count_q == CW'(N_CREDITS));
    pop      = o_valid & i_ready;
    push     = i_valid & (~full | pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    credit_d = pop;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // Storage is deliberately left out of reset; o_valid masks stale contents.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_valid  = (count_q != '0);
  assign o_data   = mem_q[rd_ptr_q];
  assign o_credit = credit_q;
  assign o_count  = count_q;

`ifdef CREDIT_RX_OVF_DET_EN
  logic ovf_q, ovf_d;
  logic ovf_event;

  always_comb begin
    ovf_event = i_valid & full & ~pop;
    ovf_d     = ovf_q | ovf_event;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (ovf_event) begin
        $error("credit_rx_buffer: word launched into full buffer without credit");
      end
    end
  end

  assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_credit_rx_buffer.sv
// tb/tb_credit_rx_buffer.sv - directed and random checks of credit_rx_buffer against a queue model
module tb_credit_rx_buffer;

  logic        clock = 1'b0;
  logic        rst_a, rst_b;
  logic        a_ivalid, a_iready, a_ovalid, a_credit;
  logic [31:0] a_idata, a_odata;
  logic [3:0]  a_count;
  logic        b_ivalid, b_iready, b_ovalid, b_credit;
  logic [31:0] b_idata, b_odata;
  logic [1:0]  b_count;
`ifdef CREDIT_RX_OVF_DET_EN
  logic        a_ovf, b_ovf;
  bit          ovf_a_exp;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          exp_ca, exp_cb;

  always #5 clock = ~clock;

  credit_rx_buffer #(.N_CREDITS(10), .DATA_WIDTH(32)) dut_a (
    .clock(clock), .reset_n(rst_a), .i_valid(a_ivalid), .i_data(a_idata),
    .o_valid(a_ovalid), .o_data(a_odata), .i_ready(a_iready), .o_credit(a_credit),
`ifdef CREDIT_RX_OVF_DET_EN
    .o_overflow(a_ovf),
`endif
    .o_count(a_count)
  );

  credit_rx_buffer #(.N_CREDITS(3), .DATA_WIDTH(32)) dut_b (
    .clock(clock), .reset_n(rst_b), .i_valid(b_ivalid), .i_data(b_idata),
    .o_valid(b_ovalid), .o_data(b_odata), .i_ready(b_iready), .o_credit(b_credit),
`ifdef CREDIT_RX_OVF_DET_EN
    .o_overflow(b_ovf),
`endif
    .o_count(b_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_a();
    check("a_valid", 64'(a_ovalid), 64'(qa.size() != 0));
    check("a_count", 64'(a_count), 64'(qa.size()));
    check("a_credit", 64'(a_credit), 64'(exp_ca));
    if (qa.size() != 0) check("a_data", 64'(a_odata), 64'(qa[0]));
`ifdef CREDIT_RX_OVF_DET_EN
    check("a_ovf", 64'(a_ovf), 64'(ovf_a_exp));
`endif
  endtask

  // One clock of DUT A: a slot is available when not full or when the head leaves this cycle.
  task automatic cyc_a(input bit v, input logic [31:0] d, input bit r);
    bit pop, push;
    a_ivalid = v; a_idata = d; a_iready = r;
    pop  = (qa.size() != 0) && r;
    push = v && (qa.size() != 10 || pop);
`ifdef CREDIT_RX_OVF_DET_EN
    if (v && !push) ovf_a_exp = 1'b1;
`endif
    @(posedge clock); #1;
    if (pop) void'(qa.pop_front());
    if (push) qa.push_back(d);
    exp_ca = pop;
    check_a();
  endtask

  task automatic reset_a_mid();
    a_ivalid = 1'b0; a_iready = 1'b0;
    #3 rst_a = 1'b0;
    #1;
    check("a_rst_valid", 64'(a_ovalid), 64'd0);
    check("a_rst_count", 64'(a_count), 64'd0);
    check("a_rst_credit", 64'(a_credit), 64'd0);
    qa.delete();
    exp_ca = 1'b0;
`ifdef CREDIT_RX_OVF_DET_EN
    ovf_a_exp = 1'b0;
`endif
    @(posedge clock); #3 rst_a = 1'b1;
    @(posedge clock); #1;
    check_a();
  endtask

  initial begin
    int cr, pend, popped, returned;
    bit v, r, pop, push;
    logic [31:0] d;

    rst_a = 1'b0; rst_b = 1'b0;
    a_ivalid = 0; a_iready = 0; a_idata = '0;
    b_ivalid = 0; b_iready = 0; b_idata = '0;
    exp_ca = 0; exp_cb = 0;
`ifdef CREDIT_RX_OVF_DET_EN
    ovf_a_exp = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    check_a();
    rst_a = 1'b1;

    repeat (10) cyc_a(1'b0, '0, 1'b0);
    cyc_a(1'b1, 32'h77, 1'b0);
    reset_a_mid();

    for (int i = 1; i <= 10; i++) cyc_a(1'b1, 32'(i), 1'b0);
    check("a_full_count", 64'(a_count), 64'd10);
    check("a_full_head", 64'(a_odata), 64'h1);
    for (int i = 0; i < 10; i++) cyc_a(1'b0, '0, 1'b1);
    cyc_a(1'b0, '0, 1'b0);

    for (int i = 0; i < 10; i++) cyc_a(1'b1, 32'(100 + i), 1'b0);
    for (int i = 0; i < 20; i++) cyc_a(1'b1, 32'(200 + i), 1'b1);

    cyc_a(1'b1, 32'hBAD, 1'b0);
    check("a_drop_count", 64'(a_count), 64'd10);
    repeat (2) cyc_a(1'b0, '0, 1'b0);

    for (int i = 0; i < 11; i++) cyc_a(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 32'(16 + i), 1'b0);
    for (int i = 0; i < 3; i++) cyc_a(1'b0, '0, 1'b1);
    reset_a_mid();
    cyc_a(1'b1, 32'h55, 1'b0);
    check("a_post_rst_head", 64'(a_odata), 64'h55);
    cyc_a(1'b0, '0, 1'b1);

    // Random traffic on the depth-3 instance, paced by a model sender credit counter.
    rst_b = 1'b1;
    cr = 3; pend = 0; popped = 0; returned = 0;
    for (int c = 0; c < 10000; c++) begin
      v = (cr > 0) && ($urandom_range(0, 2) != 0);
      r = (c >= 9990) || ($urandom_range(0, 3) != 0);
      d = $urandom;
      b_ivalid = v; b_idata = d; b_iready = r;
      pop  = (qb.size() != 0) && r;
      push = v && (qb.size() != 3 || pop);
      if (v) cr--;
      cr += pend;
      @(posedge clock); #1;
      if (pop) begin void'(qb.pop_front()); popped++; end
      if (push) qb.push_back(d);
      exp_cb = pop;
      pend = int'(b_credit);
      returned += int'(b_credit);
      check("b_valid", 64'(b_ovalid), 64'(qb.size() != 0));
      check("b_count", 64'(b_count), 64'(qb.size()));
      check("b_credit", 64'(b_credit), 64'(exp_cb));
      if (qb.size() != 0) check("b_data", 64'(b_odata), 64'(qb[0]));
      check("b_credit_bound", 64'(cr + pend <= 3), 64'd1);
    end
    b_ivalid = 1'b0;
    @(posedge clock); #1;
    returned += int'(b_credit);
    check("b_returned_eq_popped", 64'(returned), 64'(popped));
    check("b_all_credits_home", 64'(cr + pend + int'(b_credit)), 64'd3);
`ifdef CREDIT_RX_OVF_DET_EN
    check("b_ovf", 64'(b_ovf), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
